// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolution engine.
package conv_pkg;

    localparam int IMG_ROWS = 10;
    localparam int IMG_COLS = 12;
    localparam int PIX_W    = 4;
    localparam int KER_W    = 4;
    localparam int OUT_W    = 9;
    localparam int ADDR_W   = 7;

    localparam int OUT_ROWS = IMG_ROWS - 2;
    localparam int OUT_COLS = IMG_COLS - 2;
    localparam int N_TAPS   = 9;
    localparam int N_RES    = OUT_ROWS * OUT_COLS;
    localparam int PROD_W   = PIX_W + KER_W;
    // 9 * 15 * 15 = 2025 fits in 12 bits, so the accumulator never wraps
    localparam int ACC_W    = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DRAIN,
        ST_STORE,
        ST_DONE,
        ST_WAIT_REL
    } state_t;

endpackage

// File: rtl/conv_mac.sv
// Registered unsigned multiply-accumulate with clear/enable and a
// saturated OUT_W-bit view of the running sum.
module conv_mac
    import conv_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_pix,
    input  logic [KER_W-1:0] i_ker,
    output logic [OUT_W-1:0] o_sat
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OUT_W) - 1);

    logic [ACC_W-1:0]  r_acc;
    logic [PROD_W-1:0] w_prod;

    assign w_prod = PROD_W'(i_pix) * PROD_W'(i_ker);

    // Accumulator: clear wins over enable so STORE can restart the sum cleanly
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    assign o_sat = (r_acc > SAT_MAX) ? {OUT_W{1'b1}} : r_acc[OUT_W-1:0];

endmodule

// File: rtl/conv3x3_engine.sv
// Sequential 3x3 convolution over a 10x12 image: one MAC per cycle,
// 80 saturated results kept in a register bank exposed as a flat bus.
module conv3x3_engine
    import conv_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [N_TAPS*KER_W-1:0]   i_kernel_flat,
    output logic [ADDR_W-1:0]         o_img_addr,
    input  logic [PIX_W-1:0]          i_img_rd_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [N_RES*OUT_W-1:0]    o_res_flat
);

    localparam int R_W = $clog2(OUT_ROWS);
    localparam int C_W = $clog2(OUT_COLS);
    localparam int T_W = $clog2(N_TAPS + 1);
    localparam int I_W = $clog2(N_RES);

    state_t                        r_state, w_state_nxt;
    logic [T_W-1:0]                r_tap, r_mac_tap;
    logic [R_W-1:0]                r_row;
    logic [C_W-1:0]                r_col;
    logic [N_TAPS-1:0][KER_W-1:0]  r_ker;
    logic [ADDR_W-1:0]             r_addr_hold, w_addr;
    logic [1:0]                    w_kr, w_kc;
    logic                          r_mac_en, w_mac_clr, w_last;
    logic [OUT_W-1:0]              w_sat;
    logic [N_RES-1:0][OUT_W-1:0]   r_res;
    logic [I_W-1:0]                w_res_idx;

    assign w_kr      = 2'(r_tap / T_W'(3));
    assign w_kc      = 2'(r_tap % T_W'(3));
    assign w_addr    = (ADDR_W'(r_row) + ADDR_W'(w_kr)) * ADDR_W'(IMG_COLS)
                     + ADDR_W'(r_col) + ADDR_W'(w_kc);
    assign w_res_idx = I_W'(r_row) * I_W'(OUT_COLS) + I_W'(r_col);
    assign w_last    = (r_row == R_W'(OUT_ROWS - 1)) && (r_col == C_W'(OUT_COLS - 1));
    assign w_mac_clr = (r_state == ST_LOAD) || (r_state == ST_STORE);

    // Address is live during FETCH and frozen at its last value otherwise
    assign o_img_addr = (r_state == ST_FETCH) ? w_addr : r_addr_hold;
    assign o_res_flat = r_res;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start)
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (r_tap == T_W'(N_TAPS - 1))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_state_nxt = ST_STORE;
            ST_STORE: w_state_nxt = w_last ? ST_DONE : ST_FETCH;
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                // Require start to drop so one assertion yields one run
                o_busy = 1'b0;
                if (!i_start)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tap / column / row counters walking the output grid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tap <= '0;
            r_row <= '0;
            r_col <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_tap <= '0;
                    r_row <= '0;
                    r_col <= '0;
                end
                ST_FETCH: r_tap <= r_tap + 1'b1;
                ST_STORE: begin
                    r_tap <= '0;
                    if (r_col == C_W'(OUT_COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hold the last fetch address and delay the tap index to line up with RAM data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr_hold <= '0;
            r_mac_en    <= 1'b0;
            r_mac_tap   <= '0;
        end else begin
            r_mac_en <= (r_state == ST_FETCH);
            if (r_state == ST_FETCH) begin
                r_addr_hold <= w_addr;
                r_mac_tap   <= r_tap;
            end
        end
    end

    // Kernel snapshot taken at LOAD so later input changes do not disturb the run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ker <= '0;
        else if (r_state == ST_LOAD)
            r_ker <= i_kernel_flat;
    end

    conv_mac u_mac (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_mac_clr),
        .i_en  (r_mac_en),
        .i_pix (i_img_rd_data),
        .i_ker (r_ker[r_mac_tap]),
        .o_sat (w_sat)
    );

    // Result bank: one entry written per STORE, untouched otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_res <= '0;
        else if (r_state == ST_STORE)
            r_res[w_res_idx] <= w_sat;
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: directed and random images,
// reference convolution computed with plain loops.
module tb_conv3x3_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [35:0]  kernel_flat = '0;
    logic [6:0]   img_addr;
    logic [3:0]   img_rd_data = '0;
    logic         busy, done;
    logic [719:0] res_flat;

    logic [3:0]   mem [0:119];
    logic [3:0]   ker [0:8];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    localparam int TR0  [9] = '{0, 1, 2, 12, 13, 14, 24, 25, 26};
    localparam int TR79 [9] = '{93, 94, 95, 105, 106, 107, 117, 118, 119};

    conv3x3_engine dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_kernel_flat (kernel_flat),
        .o_img_addr    (img_addr),
        .i_img_rd_data (img_rd_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_res_flat    (res_flat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read image RAM: data for an address appears the next cycle
    always @(posedge clk) img_rd_data <= (img_addr < 7'd120) ? mem[img_addr] : 4'h0;

    function automatic logic [719:0] model();
        logic [719:0] m;
        m = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 10; c++) begin
                int acc;
                acc = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        acc += int'(mem[(r + kr) * 12 + c + kc]) * int'(ker[kr * 3 + kc]);
                if (acc > 511) acc = 511;
                m[(r * 10 + c) * 9 +: 9] = 9'(acc);
            end
        return m;
    endfunction

    task automatic check(input string tag, input logic [719:0] obs, input logic [719:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load_kernel();
        for (int k = 0; k < 9; k++) kernel_flat[4 * k +: 4] = ker[k];
    endtask

    // One full run; start is held for 'hold' cycles, optional mid-run start pulse,
    // optional kernel scrambling after LOAD, optional address trace check.
    task automatic do_run(input string tag, input int hold, input bit pulse_mid,
                          input bit scramble, input bit trace);
        logic [719:0] exp;
        int base, rel, n_done, done_at, limit;
        logic busy882, busy883;
        logic [6:0] tr0 [9];
        logic [6:0] tr79 [9];
        exp = model();
        @(negedge clk);
        load_kernel();
        start = 1'b1;
        @(posedge clk);
        #1;
        base    = cyc - 1;
        n_done  = 0;
        done_at = -1;
        busy882 = 1'b0;
        busy883 = 1'b1;
        limit   = (hold > 880) ? hold + 20 : 900;
        rel     = 0;
        while (rel < limit) begin
            @(negedge clk);
            rel = cyc - base;
            if (rel >= hold) start = 1'b0;
            if (pulse_mid && (rel == 300 || rel == 301)) start = 1'b1;
            if (scramble && rel >= 2) kernel_flat = 36'({$urandom(), $urandom()});
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = rel;
            end
            if (rel == 882) busy882 = busy;
            if (rel == 883) busy883 = busy;
            if (rel >= 2 && rel <= 10) tr0[rel - 2] = img_addr;
            if (rel >= 871 && rel <= 879) tr79[rel - 871] = img_addr;
        end
        start = 1'b0;
        check({tag, " done_cnt"}, 720'(n_done), 720'(1));
        check({tag, " done_cyc"}, 720'(done_at), 720'(882));
        check({tag, " busy@882"}, 720'(busy882), 720'(1));
        check({tag, " busy@883"}, 720'(busy883), 720'(0));
        check({tag, " res"}, res_flat, exp);
        if (trace) begin
            for (int i = 0; i < 9; i++) begin
                check({tag, " addr_out0"}, 720'(tr0[i]), 720'(TR0[i]));
                check({tag, " addr_out79"}, 720'(tr79[i]), 720'(TR79[i]));
            end
        end
    endtask

    task automatic rand_setup();
        for (int i = 0; i < 120; i++) mem[i] = 4'($urandom_range(0, 15));
        for (int k = 0; k < 9; k++) ker[k] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int base, rel, n_done, n_busy;
        for (int i = 0; i < 120; i++) mem[i] = 4'h0;
        for (int k = 0; k < 9; k++) ker[k] = 4'h0;

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst busy", 720'(busy), 720'(0));
        check("rst done", 720'(done), 720'(0));
        check("rst addr", 720'(img_addr), 720'(0));
        check("rst res", res_flat, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-ones image and kernel: every result is 9
        for (int i = 0; i < 120; i++) mem[i] = 4'h1;
        for (int k = 0; k < 9; k++) ker[k] = 4'h1;
        do_run("ones", 1, 1'b0, 1'b0, 1'b1);
        check("ones all9", res_flat, {80{9'd9}});

        // Centre-tap kernel over a ramp image: result is the centre pixel
        for (int i = 0; i < 120; i++) mem[i] = 4'(i % 16);
        for (int k = 0; k < 9; k++) ker[k] = (k == 4) ? 4'h1 : 4'h0;
        do_run("centre", 1, 1'b0, 1'b0, 1'b0);
        check("centre r0c0", 720'(res_flat[8:0]), 720'(mem[13]));
        check("centre r7c9", 720'(res_flat[79*9 +: 9]), 720'(mem[8*12 + 10]));

        // All-15: accumulator 2025 saturates to 511
        for (int i = 0; i < 120; i++) mem[i] = 4'hf;
        for (int k = 0; k < 9; k++) ker[k] = 4'hf;
        do_run("sat", 1, 1'b0, 1'b0, 1'b0);
        check("sat all511", res_flat, {80{9'd511}});

        // Start held high for 2000 cycles: exactly one run
        rand_setup();
        do_run("hold", 2000, 1'b0, 1'b0, 1'b0);

        // Start pulse while busy and kernel changing after LOAD: both ignored
        rand_setup();
        do_run("midpulse", 1, 1'b1, 1'b1, 1'b0);

        // Reset at cycle 400 of a run
        rand_setup();
        @(negedge clk);
        load_kernel();
        start = 1'b1;
        @(posedge clk);
        #1;
        base = cyc - 1;
        rel  = 0;
        while (rel < 400) begin
            @(negedge clk);
            rel = cyc - base;
            if (rel >= 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst busy", 720'(busy), 720'(0));
        check("midrst done", 720'(done), 720'(0));
        check("midrst addr", 720'(img_addr), 720'(0));
        check("midrst res", res_flat, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        n_busy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("midrst no_done", 720'(n_done), 720'(0));
        check("midrst no_busy", 720'(n_busy), 720'(0));
        check("midrst res_hold", res_flat, '0);

        // Clean runs after the abandoned one
        do_run("post_rst", 1, 1'b0, 1'b0, 1'b1);
        rand_setup();
        do_run("rand2", 3, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
